rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback (WB) and a multi-cycle execution unit (mul/div). It keeps a per-register busy scoreboard for outstanding multi-cycle destinations and generates the ID-stage stall. It sits between the WB stage, the multi-cycle unit and the register file write inputs (regWrite/writeReg/writeData). A starvation counter guarantees forward progress for the multi-cycle unit.

## Interface
- XLEN, 32: data width
- STARVE_LIMIT, 4: consecutive denied cycles before the multi-cycle unit forces an ID stall; must be ≥1
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- wb_valid  in  1  WB stage writes this cycle
- wb_rd  in  5  WB destination
- wb_data  in  XLEN  WB result
- mc_issue  in  1  EX issues a multi-cycle op this cycle
- mc_issue_rd  in  5  its destination
- mc_valid  in  1  multi-cycle result available; held until granted
- mc_rd  in  5  result destination
- mc_data  in  XLEN  result data
- mc_ready  out  1  multi-cycle result accepted this cycle
- id_rs1, id_rs2, id_rd  in  5 each  ID-stage register fields
- id_use_rs1, id_use_rs2, id_use_rd  in  1 each  field is meaningful
- stall_id  out  1  freeze IF/ID, inject bubble into EX
- rf_we  out  1  register file write enable
- rf_waddr  out  5  register file write address
- rf_wdata  out  XLEN  register file write data

## Operation
- State: busy[31:0] scoreboard, starve_cnt (width clog2(STARVE_LIMIT+1)), starve_hold flag.
- WB always wins; it has no backpressure. wb_real = wb_valid && wb_rd != 0.
- mc_ready = !wb_real || ... no: mc_ready = !wb_real. WB writes to x0 do not occupy the port.
- Write mux:
  - if wb_real: rf_we=1, rf_waddr=wb_rd, rf_wdata=wb_data.
  - else if mc_valid && mc_rd != 0: rf_we=1, rf_waddr=mc_rd, rf_wdata=mc_data.
  - else: rf_we=0, rf_waddr=0, rf_wdata=0.
- grant = mc_valid && mc_ready. A grant to mc_rd=0 completes without writing.
- Scoreboard:
  - set busy[mc_issue_rd] on mc_issue when mc_issue_rd != 0.
  - clear busy[mc_rd] on grant.
  - If set and clear hit the same register in the same cycle, set wins.
  - busy[0] is always 0.
- Hazard:
  - stall_id = (id_use_rs1 && busy[id_rs1]) || (id_use_rs2 && busy[id_rs2]) || (id_use_rd && busy[id_rd]) || starve_hold.
  - The id_use_rd term blocks WAW, so mc_issue never targets a busy register.
- Starvation:
  - starve_cnt increments on each cycle with mc_valid && !mc_ready, saturating at STARVE_LIMIT.
  - starve_cnt resets to 0 on grant or when mc_valid=0.
  - starve_hold is registered: it is set at the edge where the count reaches STARVE_LIMIT and cleared at the edge following a grant.
  - The resulting ID stall drains bubbles into WB, so a grant is guaranteed.
- Reset (synchronous): busy=0, starve_cnt=0, starve_hold=0. While reset is high, rf_we, mc_ready and stall_id are forced to 0.

## Timing
- rf_we/rf_waddr/rf_wdata/mc_ready are combinational from the same-cycle inputs. The register file commits at the next rising edge.
- stall_id is combinational from registered busy/starve_hold plus the same-cycle ID fields.
- Issue at edge N: busy is visible and stall_id can assert from cycle N+1.
- Grant in cycle G: stall_id still reflects busy in cycle G. Busy clears at edge G+1, together with the RF write, so the dependent instruction reads the committed value in G+1 with no forwarding needed.
- Starvation: with mc_valid denied continuously from cycle 0, starve_hold is high from cycle STARVE_LIMIT until the edge after the grant.
- Reset mid-operation: pending busy bits and the starvation state are discarded at the reset edge. Pending mc results are lost, and the multi-cycle unit is reset by the same signal.

## Test plan
- Reset, then wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in the same cycle; mc_ready=1 only when wb_valid=0.
- mc_issue rd=7; next cycle id_rs1=7 with use -> stall_id=1. Then mc_valid, mc_rd=7, data 0x12345678 with wb idle -> mc_ready=1, write to x7; stall_id=0 the cycle after.
- Contention: wb_valid=1 (rd=3) on the same cycle as mc_valid (rd=9) -> WB written, mc_ready=0. The next cycle with WB idle -> x9 written.
- Starvation with STARVE_LIMIT=4: WB busy continuously, mc_valid held -> stall_id=1 from cycle 4. Drop wb_valid in cycle 6 -> grant in 6, stall_id=0 in 7.
- x0 cases: mc_issue rd=0 -> busy unchanged, no stall; wb_rd=0 with mc_valid -> mc granted the same cycle.
- Same-cycle grant of rd=4 and mc_issue rd=4 -> busy[4] remains 1; reset asserted mid-busy -> all busy clear and stall_id=0 after the reset edge.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
// Bundle of the WB, multi-cycle unit, ID-stage and register-file write signals
// shared between the pipeline (master) and the write-port arbiter (slave).
interface rf_write_arbiter_if #(
  parameter int XLEN = 32
);
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            mc_issue;
  logic [4:0]      mc_issue_rd;
  logic            mc_valid;
  logic [4:0]      mc_rd;
  logic [XLEN-1:0] mc_data;
  logic            mc_ready;

  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic            id_use_rd;
  logic            stall_id;

  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  modport master (
    output wb_valid, wb_rd, wb_data,
    output mc_issue, mc_issue_rd, mc_valid, mc_rd, mc_data,
    input  mc_ready,
    output id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_use_rd,
    input  stall_id,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  mc_issue, mc_issue_rd, mc_valid, mc_rd, mc_data,
    output mc_ready,
    input  id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_use_rd,
    output stall_id,
    output rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB has priority over the multi-cycle unit,
// with a busy scoreboard for ID hazards and a starvation guard for the mc unit.
module rf_write_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk_i,
  input logic                rst_i,
  rf_write_arbiter_if.slave  bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [31:0]   busy_q, busy_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          starve_hold_q, starve_hold_d;

  logic wb_real;
  logic mc_ready;
  logic grant;

  assign wb_real  = bus.wb_valid && (bus.wb_rd != 5'd0);
  // WB writes to x0 leave the port free for the multi-cycle unit.
  assign mc_ready = !rst_i && !wb_real;
  assign grant    = bus.mc_valid && mc_ready;

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = 5'd0;
    bus.rf_wdata = '0;
    if (!rst_i) begin
      if (wb_real) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.wb_rd;
        bus.rf_wdata = bus.wb_data;
      end else if (bus.mc_valid && (bus.mc_rd != 5'd0)) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.mc_rd;
        bus.rf_wdata = bus.mc_data;
      end
    end
  end

  assign bus.mc_ready = mc_ready;

  always_comb begin
    bus.stall_id = 1'b0;
    if (!rst_i) begin
      bus.stall_id = (bus.id_use_rs1 && busy_q[bus.id_rs1]) ||
                     (bus.id_use_rs2 && busy_q[bus.id_rs2]) ||
                     (bus.id_use_rd  && busy_q[bus.id_rd])  ||
                     starve_hold_q;
    end
  end

  // Clear before set so a same-cycle issue to the retiring register stays busy.
  always_comb begin
    busy_d = busy_q;
    if (grant) begin
      busy_d[bus.mc_rd] = 1'b0;
    end
    if (bus.mc_issue && (bus.mc_issue_rd != 5'd0)) begin
      busy_d[bus.mc_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.mc_valid || grant) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < LIMIT) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
    starve_hold_d = (starve_hold_q && !grant) || (starve_cnt_d == LIMIT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q        <= '0;
      starve_cnt_q  <= '0;
      starve_hold_q <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      starve_cnt_q  <= starve_cnt_d;
      starve_hold_q <= starve_hold_d;
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: expected RF writes are queued as each
// step is driven and popped/compared mid-cycle against the write port.
module tb_rf_write_arbiter;
  localparam int XLEN = 32;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  rf_write_arbiter_if #(.XLEN(XLEN)) bus ();

  rf_write_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct packed {
    logic            we;
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic we, input logic [4:0] addr, input logic [XLEN-1:0] data);
    wr_t w;
    w.we = we; w.addr = addr; w.data = data;
    exp_q.push_back(w);
  endtask

  // Wait to mid-cycle and retire any queued write expectation.
  task automatic mid(input string tag);
    wr_t w;
    @(negedge clk_i);
    if (exp_q.size() != 0) begin
      w = exp_q.pop_front();
      chk({tag, ".we"},    64'(bus.rf_we),    64'(w.we));
      chk({tag, ".waddr"}, 64'(bus.rf_waddr), 64'(w.addr));
      chk({tag, ".wdata"}, 64'(bus.rf_wdata), 64'(w.data));
    end
  endtask

  task automatic next();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = '0;
    bus.mc_issue = 0; bus.mc_issue_rd = 0;
    bus.mc_valid = 0; bus.mc_rd = 0; bus.mc_data = '0;
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
    bus.id_use_rs1 = 0; bus.id_use_rs2 = 0; bus.id_use_rd = 0;
  endtask

  initial begin
    idle();
    // Outputs forced low while reset is high, even with live requests.
    bus.wb_valid = 1; bus.wb_rd = 5; bus.wb_data = 32'h1111_1111;
    bus.mc_valid = 1; bus.mc_rd = 6;
    push(0, 0, 0);
    mid("reset");
    chk("reset.mc_ready", 64'(bus.mc_ready), 0);
    chk("reset.stall_id", 64'(bus.stall_id), 0);
    next();
    next();
    rst_i = 0;

    idle();
    bus.wb_valid = 1; bus.wb_rd = 5; bus.wb_data = 32'hDEAD_BEEF;
    push(1, 5, 32'hDEAD_BEEF);
    mid("wb_write");
    chk("wb_write.mc_ready", 64'(bus.mc_ready), 0);
    next();

    idle();
    push(0, 0, 0);
    mid("idle");
    chk("idle.mc_ready", 64'(bus.mc_ready), 1);
    next();

    idle();
    bus.mc_issue = 1; bus.mc_issue_rd = 7;
    bus.id_rs1 = 7; bus.id_use_rs1 = 1;
    mid("issue7");
    chk("issue7.stall_same_cycle", 64'(bus.stall_id), 0);
    next();

    idle();
    bus.id_rs1 = 7; bus.id_use_rs1 = 1;
    mid("raw7");
    chk("raw7.stall_id", 64'(bus.stall_id), 1);
    next();

    bus.mc_valid = 1; bus.mc_rd = 7; bus.mc_data = 32'h1234_5678;
    push(1, 7, 32'h1234_5678);
    mid("grant7");
    chk("grant7.mc_ready", 64'(bus.mc_ready), 1);
    chk("grant7.stall_in_G", 64'(bus.stall_id), 1);
    next();

    bus.mc_valid = 0;
    mid("after7");
    chk("after7.stall_id", 64'(bus.stall_id), 0);
    next();

    // Contention: WB wins, mc result held and written next free cycle.
    idle();
    bus.wb_valid = 1; bus.wb_rd = 3; bus.wb_data = 32'hAAAA_0003;
    bus.mc_valid = 1; bus.mc_rd = 9; bus.mc_data = 32'hBBBB_0009;
    push(1, 3, 32'hAAAA_0003);
    mid("contend");
    chk("contend.mc_ready", 64'(bus.mc_ready), 0);
    next();

    bus.wb_valid = 0;
    push(1, 9, 32'hBBBB_0009);
    mid("deferred9");
    chk("deferred9.mc_ready", 64'(bus.mc_ready), 1);
    next();

    // Starvation: WB busy cycles 0..5, hold visible from cycle 4.
    idle();
    bus.mc_valid = 1; bus.mc_rd = 10; bus.mc_data = 32'hCAFE_000A;
    for (int c = 0; c < 6; c++) begin
      bus.wb_valid = 1; bus.wb_rd = 5'(c + 1); bus.wb_data = 32'h5000_0000 + c;
      push(1, 5'(c + 1), 32'h5000_0000 + c);
      mid($sformatf("starve_c%0d", c));
      chk($sformatf("starve_c%0d.stall_id", c), 64'(bus.stall_id), 64'(c >= 4));
      chk($sformatf("starve_c%0d.mc_ready", c), 64'(bus.mc_ready), 0);
      next();
    end
    bus.wb_valid = 0; bus.wb_rd = 0;
    push(1, 10, 32'hCAFE_000A);
    mid("starve_c6");
    chk("starve_c6.mc_ready", 64'(bus.mc_ready), 1);
    chk("starve_c6.stall_id", 64'(bus.stall_id), 1);
    next();
    idle();
    mid("starve_c7");
    chk("starve_c7.stall_id", 64'(bus.stall_id), 0);
    next();

    // x0 cases.
    bus.mc_issue = 1; bus.mc_issue_rd = 0;
    next();
    idle();
    bus.id_rs1 = 0; bus.id_use_rs1 = 1; bus.id_rd = 0; bus.id_use_rd = 1;
    mid("x0_issue");
    chk("x0_issue.stall_id", 64'(bus.stall_id), 0);
    next();

    idle();
    bus.wb_valid = 1; bus.wb_rd = 0; bus.wb_data = 32'hEEEE_EEEE;
    bus.mc_valid = 1; bus.mc_rd = 11; bus.mc_data = 32'hF00D_000B;
    push(1, 11, 32'hF00D_000B);
    mid("wb_x0");
    chk("wb_x0.mc_ready", 64'(bus.mc_ready), 1);
    next();

    idle();
    bus.mc_valid = 1; bus.mc_rd = 0; bus.mc_data = 32'h0BAD_0000;
    push(0, 0, 0);
    mid("mc_x0");
    chk("mc_x0.mc_ready", 64'(bus.mc_ready), 1);
    next();

    // Same-cycle grant and re-issue of x4: busy[4] must survive.
    idle();
    bus.mc_issue = 1; bus.mc_issue_rd = 4;
    next();
    idle();
    bus.mc_issue = 1; bus.mc_issue_rd = 4;
    bus.mc_valid = 1; bus.mc_rd = 4; bus.mc_data = 32'h4444_4444;
    push(1, 4, 32'h4444_4444);
    mid("regrant4");
    next();
    idle();
    bus.mc_issue = 1; bus.mc_issue_rd = 12;
    bus.id_rd = 4; bus.id_use_rd = 1;
    mid("busy4_kept");
    chk("busy4_kept.stall_id", 64'(bus.stall_id), 1);
    next();
    idle();
    bus.id_rs2 = 12; bus.id_use_rs2 = 1;
    mid("busy12");
    chk("busy12.stall_id", 64'(bus.stall_id), 1);
    next();

    // Reset mid-busy discards the scoreboard.
    rst_i = 1;
    next();
    rst_i = 0;
    idle();
    bus.id_rd = 4; bus.id_use_rd = 1; bus.id_rs2 = 12; bus.id_use_rs2 = 1;
    push(0, 0, 0);
    mid("post_reset");
    chk("post_reset.stall_id", 64'(bus.stall_id), 0);
    next();

    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
